// File: rtl/cache_way_ctrl.sv
// rtl/cache_way_ctrl.sv - N-way set-associative cache control: hit/enable logic, tree PLRU, miss FSM
module cache_way_ctrl #(
   parameter int WAYS  = 4,
   parameter int SETS  = 8,
   parameter int IDX_W = $clog2(SETS),
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [IDX_W-1:0] set_idx,
   input  logic [WAYS-1:0]  valid,
   input  logic [WAYS-1:0]  dirty,
   input  logic [WAYS-1:0]  tagcmp,
   input  logic             pmem_resp,
   output logic [WAYS-1:0]  hit_vec,
   output logic             hit_any,
   output logic             mem_resp,
   output logic [WAY_W-1:0] victim_way,
   output logic [WAYS-1:0]  tag_we,
   output logic [WAYS-1:0]  data_we,
   output logic             dirty_set,
   output logic             dirty_clr,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WB    = 2'd1;
   localparam logic [1:0] S_ALLOC = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WAYS-2:0]  plru [SETS];
   logic [WAY_W-1:0] victim_q;
   logic [IDX_W-1:0] set_q;

   logic             req;
   logic             idle;
   logic [WAYS-1:0]  hit_c;
   logic             hit_any_c;
   logic [WAY_W-1:0] hit_way;
   logic             any_invalid;
   logic [WAY_W-1:0] invalid_way;
   logic [WAY_W-1:0] victim_c;
   logic [WAY_W-1:0] victim_sel;
   logic [WAYS-1:0]  victim_oh;
   logic             fill_done;

   logic [WAYS-1:0]  tag_we_c;
   logic [WAYS-1:0]  data_we_c;

   // Walk the PLRU tree from the root: a 0 bit steers to the lower-index subtree.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
      int node;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         node = 2 * node + 1 + (bits[node] ? 1 : 0);
      end
      return WAY_W'(node - (WAYS - 1));
   endfunction

   // Point every node on the accessed way's path away from it.
   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                  input logic [WAY_W-1:0] way);
      logic [WAYS-2:0] r;
      logic            dir;
      int              node;
      r    = bits;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         dir     = way[WAY_W-1-l];
         r[node] = ~dir;
         node    = 2 * node + 1 + (dir ? 1 : 0);
      end
      return r;
   endfunction

   assign req       = mem_read | mem_write;
   assign idle      = (state == S_IDLE);
   assign fill_done = (state == S_ALLOC) & pmem_resp;

   // Priority-encode tag matches so an illegal multi-match reports only the lowest way.
   always_comb begin
      hit_c   = '0;
      hit_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (valid[i] & tagcmp[i] & idle & req) begin
            hit_c   = '0;
            hit_c[i] = 1'b1;
            hit_way = WAY_W'(i);
         end
      end
   end

   assign hit_any_c = |hit_c;

   // Prefer the lowest invalid way; fall back to the PLRU walk when the set is full.
   always_comb begin
      any_invalid = 1'b0;
      invalid_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            any_invalid = 1'b1;
            invalid_way = WAY_W'(i);
         end
      end
      victim_c = any_invalid ? invalid_way : plru_victim(plru[set_idx]);
   end

   assign victim_sel = idle ? victim_c : victim_q;
   assign victim_oh  = WAYS'(1) << victim_q;

   // Write enables: write hits touch the hit way, a completed fill writes the victim.
   always_comb begin
      tag_we_c  = '0;
      data_we_c = '0;
      if (hit_any_c && mem_write) begin
         data_we_c = hit_c;
      end
      if (fill_done) begin
         tag_we_c  = victim_oh;
         data_we_c = victim_oh;
      end
   end

   // Miss sequencing: write back a dirty victim first, then fill, then replay in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req && !hit_any_c) begin
               state_nxt = (valid[victim_c] & dirty[victim_c]) ? S_WB : S_ALLOC;
            end
         end
         S_WB:    if (pmem_resp) state_nxt = S_ALLOC;
         S_ALLOC: if (pmem_resp) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM state plus the victim/set captured at the moment the miss is detected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         victim_q <= '0;
         set_q    <= '0;
      end else begin
         state <= state_nxt;
         if (idle && req && !hit_any_c) begin
            victim_q <= victim_c;
            set_q    <= set_idx;
         end
      end
   end

   // PLRU is only updated by hits; fills rely on the replayed hit to touch the tree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            plru[s] <= '0;
         end
      end else if (hit_any_c) begin
         plru[set_idx] <= plru_touch(plru[set_idx], hit_way);
      end
   end

   // Outputs are forced low while reset is asserted so an in-flight transfer drops at once.
   assign hit_vec    = rst_n ? hit_c : '0;
   assign hit_any    = rst_n & hit_any_c;
   assign mem_resp   = rst_n & hit_any_c;
   assign victim_way = rst_n ? victim_sel : '0;
   assign tag_we     = rst_n ? tag_we_c : '0;
   assign data_we    = rst_n ? data_we_c : '0;
   assign dirty_set  = rst_n & hit_any_c & mem_write;
   assign dirty_clr  = rst_n & fill_done;
   assign pmem_read  = rst_n & (state == S_ALLOC);
   assign pmem_write = rst_n & (state == S_WB);
   assign busy       = rst_n & !idle;

endmodule

// File: tb/tb_cache_way_ctrl.sv
// tb/tb_cache_way_ctrl.sv - directed self-checking bench for cache_way_ctrl
module tb_cache_way_ctrl;

   localparam int WAYS = 4;
   localparam int SETS = 8;

   logic       clk;
   logic       rst_n;
   logic       mem_read;
   logic       mem_write;
   logic [2:0] set_idx;
   logic [3:0] valid;
   logic [3:0] dirty;
   logic [3:0] tagcmp;
   logic       pmem_resp;
   logic [3:0] hit_vec;
   logic       hit_any;
   logic       mem_resp;
   logic [1:0] victim_way;
   logic [3:0] tag_we;
   logic [3:0] data_we;
   logic       dirty_set;
   logic       dirty_clr;
   logic       pmem_read;
   logic       pmem_write;
   logic       busy;

   int errors = 0;
   int checks = 0;

   cache_way_ctrl #(.WAYS(WAYS), .SETS(SETS)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .set_idx(set_idx), .valid(valid), .dirty(dirty), .tagcmp(tagcmp),
      .pmem_resp(pmem_resp), .hit_vec(hit_vec), .hit_any(hit_any),
      .mem_resp(mem_resp), .victim_way(victim_way), .tag_we(tag_we),
      .data_we(data_we), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a full input vector at the falling edge and let it settle.
   task automatic drive(input logic rd, input logic wr, input logic [2:0] s,
                        input logic [3:0] v, input logic [3:0] d,
                        input logic [3:0] t, input logic pr);
      @(negedge clk);
      mem_read  = rd;
      mem_write = wr;
      set_idx   = s;
      valid     = v;
      dirty     = d;
      tagcmp    = t;
      pmem_resp = pr;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 3'd1, 4'b1111, 4'b1111, 4'b1111, 1'b1);
      checks++;
      if ({hit_vec, mem_resp, victim_way, tag_we, data_we, dirty_set, dirty_clr,
           pmem_read, pmem_write, busy, hit_any} !== 22'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {hit_vec, mem_resp, victim_way, tag_we, data_we, dirty_set,
                   dirty_clr, pmem_read, pmem_write, busy, hit_any});
      end
      drive(1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_cold_miss();
      drive(1'b1, 1'b0, 3'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd0 || hit_any !== 1'b0 || mem_resp !== 1'b0) begin
         errors++;
         $display("FAIL cold_victim: victim=%0d hit=%b resp=%b expected 0 0 0", victim_way, hit_any, mem_resp);
      end
      drive(1'b1, 1'b0, 3'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || busy !== 1'b1 || mem_resp !== 1'b0) begin
         errors++;
         $display("FAIL cold_alloc: pr=%b pw=%b busy=%b resp=%b expected 1 0 1 0", pmem_read, pmem_write, busy, mem_resp);
      end
      drive(1'b1, 1'b0, 3'd3, 4'b0000, 4'b0000, 4'b0000, 1'b1);
      checks++;
      if (tag_we !== 4'b0001 || data_we !== 4'b0001 || dirty_clr !== 1'b1) begin
         errors++;
         $display("FAIL cold_fill: tag_we=%b data_we=%b clr=%b expected 0001 0001 1", tag_we, data_we, dirty_clr);
      end
      drive(1'b1, 1'b0, 3'd3, 4'b0001, 4'b0000, 4'b0001, 1'b0);
      checks++;
      if (hit_vec !== 4'b0001 || mem_resp !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL cold_replay: hit_vec=%b resp=%b busy=%b expected 0001 1 0", hit_vec, mem_resp, busy);
      end
   endtask

   task automatic test_plru_hits();
      logic [3:0] seq [4];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
      drive(1'b1, 1'b0, 3'd5, 4'b1111, 4'b0000, 4'b0110, 1'b0);
      checks++;
      if (hit_vec !== 4'b0010 || hit_any !== 1'b1) begin
         errors++;
         $display("FAIL multi_match: hit_vec=%b hit_any=%b expected 0010 1", hit_vec, hit_any);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 3'd5, 4'b1111, 4'b0000, seq[i], 1'b0);
         checks++;
         if (hit_vec !== seq[i] || mem_resp !== 1'b1 || data_we !== 4'b0000) begin
            errors++;
            $display("FAIL read_hit_%0d: hit_vec=%b resp=%b data_we=%b expected %b 1 0000", i, hit_vec, mem_resp, data_we, seq[i]);
         end
      end
      drive(1'b0, 1'b0, 3'd5, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd0) begin
         errors++;
         $display("FAIL plru5_victim: got %0d expected 0", victim_way);
      end
      drive(1'b0, 1'b0, 3'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd0) begin
         errors++;
         $display("FAIL plru2_untouched: got %0d expected 0", victim_way);
      end
      drive(1'b0, 1'b0, 3'd3, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd2) begin
         errors++;
         $display("FAIL plru3_victim: got %0d expected 2", victim_way);
      end
      drive(1'b1, 1'b0, 3'd5, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd0) begin
         errors++;
         $display("FAIL miss5_victim: got %0d expected 0", victim_way);
      end
      drive(1'b1, 1'b0, 3'd5, 4'b1111, 4'b0000, 4'b0000, 1'b1);
      checks++;
      if (pmem_write !== 1'b0 || tag_we !== 4'b0001) begin
         errors++;
         $display("FAIL miss5_clean_fill: pw=%b tag_we=%b expected 0 0001", pmem_write, tag_we);
      end
      drive(1'b0, 1'b0, 3'd5, 4'b1111, 4'b0000, 4'b0000, 1'b0);
   endtask

   task automatic test_dirty_miss();
      drive(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0001, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd0) begin
         errors++;
         $display("FAIL dirty_victim: got %0d expected 0", victim_way);
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0001, 4'b0000, (c == 2));
         checks++;
         if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || victim_way !== 2'd0 || mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL wb_cycle_%0d: pw=%b pr=%b victim=%0d resp=%b expected 1 0 0 0", c, pmem_write, pmem_read, victim_way, mem_resp);
         end
      end
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0001, 4'b0000, 1'b0);
         checks++;
         if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || tag_we !== 4'b0000) begin
            errors++;
            $display("FAIL alloc_cycle_%0d: pr=%b pw=%b tag_we=%b expected 1 0 0000", c, pmem_read, pmem_write, tag_we);
         end
      end
      drive(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0001, 4'b0000, 1'b1);
      checks++;
      if (tag_we !== 4'b0001 || data_we !== 4'b0001 || dirty_clr !== 1'b1) begin
         errors++;
         $display("FAIL dirty_fill: tag_we=%b data_we=%b clr=%b expected 0001 0001 1", tag_we, data_we, dirty_clr);
      end
      drive(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0000, 4'b0001, 1'b0);
      checks++;
      if (hit_vec !== 4'b0001 || mem_resp !== 1'b1) begin
         errors++;
         $display("FAIL dirty_replay: hit_vec=%b resp=%b expected 0001 1", hit_vec, mem_resp);
      end
   endtask

   task automatic test_write_hit();
      drive(1'b0, 1'b1, 3'd2, 4'b1111, 4'b0000, 4'b0100, 1'b0);
      checks++;
      if (mem_resp !== 1'b1 || data_we !== 4'b0100 || dirty_set !== 1'b1 || tag_we !== 4'b0000) begin
         errors++;
         $display("FAIL write_hit: resp=%b data_we=%b dset=%b tag_we=%b expected 1 0100 1 0000", mem_resp, data_we, dirty_set, tag_we);
      end
      drive(1'b0, 1'b0, 3'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd1 || data_we !== 4'b0000 || dirty_set !== 1'b0) begin
         errors++;
         $display("FAIL write_hit_plru: victim=%0d data_we=%b dset=%b expected 1 0000 0", victim_way, data_we, dirty_set);
      end
      drive(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0000, 4'b0001, 1'b0);
      drive(1'b0, 1'b0, 3'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd3) begin
         errors++;
         $display("FAIL plru_node2: victim=%0d expected 3", victim_way);
      end
   endtask

   task automatic test_reset_mid_alloc();
      drive(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      drive(1'b1, 1'b0, 3'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (pmem_read !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_abort_alloc: pr=%b busy=%b expected 1 1", pmem_read, busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pmem_read, pmem_write, busy, mem_resp, hit_vec, victim_way, tag_we, data_we, dirty_clr, dirty_set} !== 20'd0) begin
         errors++;
         $display("FAIL abort_outputs: got %b expected all zero",
                  {pmem_read, pmem_write, busy, mem_resp, hit_vec, victim_way, tag_we, data_we, dirty_clr, dirty_set});
      end
      drive(1'b0, 1'b0, 3'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      rst_n = 1'b1;
      #1;
      checks++;
      if (victim_way !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_set2: victim=%0d busy=%b expected 0 0", victim_way, busy);
      end
      drive(1'b1, 1'b0, 3'd3, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (victim_way !== 2'd0) begin
         errors++;
         $display("FAIL post_reset_set3: victim=%0d expected 0", victim_way);
      end
      drive(1'b1, 1'b0, 3'd3, 4'b1111, 4'b0000, 4'b0000, 1'b1);
      drive(1'b0, 1'b0, 3'd3, 4'b1111, 4'b0000, 4'b0000, 1'b0);
   endtask

   task automatic test_idle_resp();
      drive(1'b0, 1'b0, 3'd4, 4'b1011, 4'b1111, 4'b1111, 1'b1);
      checks++;
      if ({tag_we, data_we, dirty_clr, dirty_set, pmem_read, pmem_write, mem_resp, hit_vec} !== 17'd0) begin
         errors++;
         $display("FAIL idle_resp_enables: got %b expected all zero",
                  {tag_we, data_we, dirty_clr, dirty_set, pmem_read, pmem_write, mem_resp, hit_vec});
      end
      checks++;
      if (victim_way !== 2'd2) begin
         errors++;
         $display("FAIL invalid_victim: got %0d expected 2", victim_way);
      end
      drive(1'b0, 1'b0, 3'd4, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      checks++;
      if (busy !== 1'b0 || pmem_read !== 1'b0 || victim_way !== 2'd0) begin
         errors++;
         $display("FAIL idle_resp_state: busy=%b pr=%b victim=%0d expected 0 0 0", busy, pmem_read, victim_way);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      set_idx   = '0;
      valid     = '0;
      dirty     = '0;
      tagcmp    = '0;
      pmem_resp = 1'b0;
      test_reset();
      test_cold_miss();
      test_plru_hits();
      test_dirty_miss();
      test_write_hit();
      test_reset_mid_alloc();
      test_idle_resp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_way_ctrl.md
Name: cache_way_ctrl

Overview:
Parametrised N-way set-associative cache control. It is the successor to the fixed 2-way hit/enable logic.
- Combinational part: per-way hit detection and write-enable generation.
- Sequential part: per-set tree pseudo-LRU state, and a miss FSM (writeback, then allocate) with a physical-memory handshake.
- Position: between the cache datapath (tag/valid/dirty/data arrays, tag comparators) and the pmem arbiter.

Parameters:
- WAYS, 4, associativity. Power of 2, minimum 2.
- SETS, 8, number of sets. Power of 2.
- IDX_W, $clog2(SETS), set index width.
- WAY_W, $clog2(WAYS), way index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  CPU read request. Held until mem_resp.
- mem_write  in  1  CPU write request. Held until mem_resp.
- set_idx  in  IDX_W  set of the current request.
- valid  in  WAYS  valid bit per way for set_idx.
- dirty  in  WAYS  dirty bit per way for set_idx.
- tagcmp  in  WAYS  tag-match per way for set_idx.
- pmem_resp  in  1  pmem transfer complete. Single-cycle pulse.
- hit_vec  out  WAYS  one-hot hit way.
- hit_any  out  1  OR of hit_vec.
- mem_resp  out  1  request complete.
- victim_way  out  WAY_W  way selected for replacement. Drives datapath muxes.
- tag_we  out  WAYS  tag+valid write enable per way.
- data_we  out  WAYS  data+dirty write enable per way.
- dirty_set  out  1  value written to dirty on a write hit.
- dirty_clr  out  1  dirty written 0 on allocate.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  writeback request.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: asynchronous on rst_n low.
  - FSM goes to IDLE.
  - All PLRU bits of all sets clear to 0.
  - Latched victim and latched set clear to 0.
  - Every output is 0.
  - Reset mid-WB/ALLOC aborts the transfer immediately. pmem_read/pmem_write drop in the same cycle.
- Hit detection: hit_vec[i] = valid[i] & tagcmp[i] & (state==IDLE) & (mem_read|mem_write).
  - If several ways match (illegal), only the lowest index is reported.
- IDLE, hit:
  - mem_resp=1 in the same cycle (combinational, zero-wait hit).
  - On a write: data_we[hit way]=1 and dirty_set=1.
  - At the clock edge, PLRU[set_idx] is updated toward the hit way.
- PLRU:
  - WAYS-1 bits per set, heap-ordered: node 0 is the root; the children of node n are 2n+1 and 2n+2.
  - Victim walk: bit 0 selects the lower-index subtree, bit 1 the upper.
  - Access update: each node on the path is set to point away from the accessed way (1 if the access went lower, 0 if upper).
  - Bits of other sets are untouched.
- Victim selection, computed combinationally in IDLE:
  - The lowest-index invalid way if any valid bit is 0.
  - Otherwise the PLRU walk.
- IDLE, miss (request present and hit_any=0): latch victim and set_idx. Next state:
  - WB if valid[victim] & dirty[victim].
  - ALLOC otherwise.
- WB:
  - pmem_write=1 and victim_way=latched victim, held until pmem_resp.
  - On pmem_resp go to ALLOC.
- ALLOC:
  - pmem_read=1, held until pmem_resp.
  - In the pmem_resp cycle: tag_we[victim]=1, data_we[victim]=1, dirty_clr=1. Next state is IDLE.
  - A fill does not update PLRU. The replayed hit in the following IDLE cycle updates it.
- Miss latency: 1 + WB cycles + ALLOC cycles + 1 replay cycle.
- mem_resp is never asserted outside IDLE.
- pmem_read and pmem_write are never asserted together.
- pmem_resp in IDLE is ignored.
- No request in IDLE: all enables 0 and no PLRU update.

Test Plan (WAYS=4, SETS=8):
1. Reset, then mem_read at set 3 with valid=0000 → victim_way=0, next state ALLOC with pmem_read=1. Pulse pmem_resp → tag_we=0001, data_we=0001, dirty_clr=1. Next cycle, with valid=0001 and tagcmp=0001 → hit_vec=0001 and mem_resp=1.
2. Set 5 all valid. Read hits on ways 0,1,2,3 in successive cycles → PLRU[5]=000. A following miss selects victim_way=0. Set 2's PLRU bits remain 000 throughout.
3. Miss with victim dirty (valid=1111, dirty=0001, PLRU=000) → pmem_write=1 for 3 cycles until pmem_resp, then pmem_read=1 until pmem_resp. Then tag_we=0001, then the replay hit.
4. Write hit on way 2 → mem_resp=1, data_we=0100, dirty_set=1 in the same cycle. PLRU[set] becomes root=0, node2=1 (node1 unchanged).
5. Drop rst_n mid-ALLOC → pmem_read=0, busy=0, all outputs 0 immediately. After release, all PLRU bits are 0 (a full-valid miss picks way 0).
6. pmem_resp pulsed while in IDLE with no request → no state change and all enables stay 0.
